// File: rtl/cmm_pip_rr_arb.sv
// Packet-locked round-robin arbiter feeding one full-throughput output register slice.
// Upstream readies come combinationally from i_out_ready through the stage-accept term.
module cmm_pip_rr_arb #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned DWIDTH = 16,
   parameter int unsigned IDW    = 2
) (
   input  logic                     i_clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          i_req_valid,
   input  logic [NREQ*DWIDTH-1:0]   i_req_data,
   input  logic [NREQ-1:0]          i_req_last,
   output logic [NREQ-1:0]          o_req_ready,
   input  logic                     i_out_ready,
   output logic                     o_out_valid,
   output logic [DWIDTH-1:0]        o_out_data,
   output logic                     o_out_last,
   output logic [IDW-1:0]           o_out_id,
   output logic                     o_busy
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [IDW-1:0]      ptr_q, ptr_d;
   logic [IDW-1:0]      owner_q, owner_d;
   logic                out_valid_q, out_valid_d;
   logic [DWIDTH-1:0]   out_data_q, out_data_d;
   logic                out_last_q, out_last_d;
   logic [IDW-1:0]      out_id_q, out_id_d;

   logic                can_acc;
   logic                grant_vld;
   logic [IDW-1:0]      gnt_idx;
   logic                gnt_req_vld;
   logic                gnt_req_last;
   logic [DWIDTH-1:0]   gnt_req_data;
   logic                acc;
   logic                rr_found;
   logic [IDW-1:0]      rr_idx;

   // Round-robin scan starting at ptr_q, wrapping modulo NREQ.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         for (int unsigned j = 0; j < NREQ; j++) begin
            if (!rr_found && (((32'(ptr_q) + i) % NREQ) == j) && i_req_valid[j]) begin
               rr_found = 1'b1;
               rr_idx   = IDW'(j);
            end
         end
      end
   end

   // Locked owner keeps the grant even while it bubbles.
   always_comb begin
      grant_vld = 1'b0;
      gnt_idx   = '0;
      if (state_q == ST_LOCKED) begin
         grant_vld = 1'b1;
         gnt_idx   = owner_q;
      end else begin
         grant_vld = rr_found;
         gnt_idx   = rr_idx;
      end
   end

   always_comb begin
      gnt_req_vld  = 1'b0;
      gnt_req_last = 1'b0;
      gnt_req_data = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (gnt_idx == IDW'(k)) begin
            gnt_req_vld  = i_req_valid[k];
            gnt_req_last = i_req_last[k];
            gnt_req_data = i_req_data[k*DWIDTH +: DWIDTH];
         end
      end
   end

   assign can_acc     = !out_valid_q || i_out_ready;
   assign o_req_ready = (can_acc && grant_vld) ? (NREQ'(1) << gnt_idx) : '0;
   assign acc         = can_acc && grant_vld && gnt_req_vld;

   // Next-state: lock/pointer FSM plus output slice.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_id_d    = out_id_q;

      if (acc) begin
         out_valid_d = 1'b1;
         out_data_d  = gnt_req_data;
         out_last_d  = gnt_req_last;
         out_id_d    = gnt_idx;
      end else if (i_out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (acc) begin
               if (gnt_req_last) begin
                  ptr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
               end else begin
                  state_d = ST_LOCKED;
                  owner_d = gnt_idx;
               end
            end
         end
         ST_LOCKED: begin
            if (acc && gnt_req_last) begin
               state_d = ST_IDLE;
               ptr_d   = (32'(owner_q) == NREQ - 1) ? '0 : owner_q + IDW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_id_q    <= out_id_d;
      end
   end

   assign o_out_valid = out_valid_q;
   assign o_out_data  = out_data_q;
   assign o_out_last  = out_last_q;
   assign o_out_id    = out_id_q;
   assign o_busy      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_cmm_pip_rr_arb.sv
// Directed table-driven bench for cmm_pip_rr_arb (NREQ=4, DWIDTH=16, IDW=2).
module tb_cmm_pip_rr_arb;

   localparam int unsigned NREQ   = 4;
   localparam int unsigned DWIDTH = 16;
   localparam int unsigned IDW    = 2;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NREQ-1:0]         req_valid;
   logic [NREQ*DWIDTH-1:0]  req_data;
   logic [NREQ-1:0]         req_last;
   logic [NREQ-1:0]         req_ready;
   logic                    out_ready;
   logic                    out_valid;
   logic [DWIDTH-1:0]       out_data;
   logic                    out_last;
   logic [IDW-1:0]          out_id;
   logic                    busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cmm_pip_rr_arb #(.NREQ(NREQ), .DWIDTH(DWIDTH), .IDW(IDW)) dut (
      .i_clk       (clk),
      .rst_n       (rst_n),
      .i_req_valid (req_valid),
      .i_req_data  (req_data),
      .i_req_last  (req_last),
      .o_req_ready (req_ready),
      .i_out_ready (out_ready),
      .o_out_valid (out_valid),
      .o_out_data  (out_data),
      .o_out_last  (out_last),
      .o_out_id    (out_id),
      .o_busy      (busy)
   );

   typedef struct {
      logic [3:0]  vld;
      logic [3:0]  last;
      logic [63:0] data;
      logic        ordy;
      logic [3:0]  e_rdy;
      logic        e_ov;
      logic [15:0] e_od;
      logic [1:0]  e_id;
      logic        e_ol;
      logic        e_busy;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [63:0] mk(input logic [15:0] r3, input logic [15:0] r2,
                                      input logic [15:0] r1, input logic [15:0] r0);
      return {r3, r2, r1, r0};
   endfunction

   task automatic add(input logic [3:0] vld, input logic [3:0] last, input logic [63:0] data,
                      input logic ordy, input logic [3:0] e_rdy, input logic e_ov,
                      input logic [15:0] e_od, input logic [1:0] e_id, input logic e_ol,
                      input logic e_busy);
      vec_t v;
      v.vld = vld; v.last = last; v.data = data; v.ordy = ordy;
      v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_id = e_id;
      v.e_ol = e_ol; v.e_busy = e_busy;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] vld, input logic [3:0] last,
                        input logic [63:0] data, input logic ordy);
      req_valid = vld;
      req_last  = last;
      req_data  = data;
      out_ready = ordy;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(4'b0000, 4'b0000, 64'h0, 1'b1);

      // Idle: nothing valid for 10 cycles.
      for (int i = 0; i < 10; i++)
         add(4'b0000, 4'b0000, 64'h0, 1'b1, 4'b0000, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
      // Alternating single-beat packets from requesters 0 and 2.
      add(4'b0101, 4'b0101, mk(16'h0, 16'hA002, 16'h0, 16'hA000), 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0);
      add(4'b0101, 4'b0101, mk(16'h0, 16'hA002, 16'h0, 16'hA000), 1'b1, 4'b0100, 1'b1, 16'hA000, 2'd0, 1'b1, 1'b0);
      add(4'b0101, 4'b0101, mk(16'h0, 16'hA002, 16'h0, 16'hA000), 1'b1, 4'b0001, 1'b1, 16'hA002, 2'd2, 1'b1, 1'b0);
      add(4'b0101, 4'b0101, mk(16'h0, 16'hA002, 16'h0, 16'hA000), 1'b1, 4'b0100, 1'b1, 16'hA000, 2'd0, 1'b1, 1'b0);
      add(4'b0101, 4'b0101, mk(16'h0, 16'hA002, 16'h0, 16'hA000), 1'b1, 4'b0001, 1'b1, 16'hA002, 2'd2, 1'b1, 1'b0);
      // Requester 1 three-beat packet, requester 3 waiting.
      add(4'b1010, 4'b1000, mk(16'h3333, 16'h0, 16'h1111, 16'h0), 1'b1, 4'b0010, 1'b1, 16'hA000, 2'd0, 1'b1, 1'b0);
      add(4'b1010, 4'b1000, mk(16'h3333, 16'h0, 16'h1112, 16'h0), 1'b1, 4'b0010, 1'b1, 16'h1111, 2'd1, 1'b0, 1'b1);
      add(4'b1010, 4'b1010, mk(16'h3333, 16'h0, 16'h1113, 16'h0), 1'b1, 4'b0010, 1'b1, 16'h1112, 2'd1, 1'b0, 1'b1);
      add(4'b1000, 4'b1000, mk(16'h3333, 16'h0, 16'h0,    16'h0), 1'b1, 4'b1000, 1'b1, 16'h1113, 2'd1, 1'b1, 1'b0);
      add(4'b0000, 4'b0000, 64'h0,                                1'b1, 4'b0000, 1'b1, 16'h3333, 2'd3, 1'b1, 1'b0);
      // Same, with a 2-cycle owner bubble mid-packet.
      add(4'b1010, 4'b1000, mk(16'h3333, 16'h0, 16'h2221, 16'h0), 1'b1, 4'b0010, 1'b0, 16'h3333, 2'd3, 1'b1, 1'b0);
      add(4'b1000, 4'b1000, mk(16'h3333, 16'h0, 16'h0,    16'h0), 1'b1, 4'b0010, 1'b1, 16'h2221, 2'd1, 1'b0, 1'b1);
      add(4'b1000, 4'b1000, mk(16'h3333, 16'h0, 16'h0,    16'h0), 1'b1, 4'b0010, 1'b0, 16'h2221, 2'd1, 1'b0, 1'b1);
      add(4'b1010, 4'b1000, mk(16'h3333, 16'h0, 16'h2222, 16'h0), 1'b1, 4'b0010, 1'b0, 16'h2221, 2'd1, 1'b0, 1'b1);
      add(4'b1010, 4'b1010, mk(16'h3333, 16'h0, 16'h2223, 16'h0), 1'b1, 4'b0010, 1'b1, 16'h2222, 2'd1, 1'b0, 1'b1);
      add(4'b1000, 4'b1000, mk(16'h3333, 16'h0, 16'h0,    16'h0), 1'b1, 4'b1000, 1'b1, 16'h2223, 2'd1, 1'b1, 1'b0);
      // Backpressure: 5 stalled cycles, then release accepts in the same cycle.
      for (int i = 0; i < 5; i++)
         add(4'b0001, 4'b0001, mk(16'h0, 16'h0, 16'h0, 16'hE000), 1'b0, 4'b0000, 1'b1, 16'h3333, 2'd3, 1'b1, 1'b0);
      add(4'b0001, 4'b0001, mk(16'h0, 16'h0, 16'h0, 16'hE000), 1'b1, 4'b0001, 1'b1, 16'h3333, 2'd3, 1'b1, 1'b0);
      add(4'b0000, 4'b0000, 64'h0,                             1'b1, 4'b0000, 1'b1, 16'hE000, 2'd0, 1'b1, 1'b0);
      add(4'b0000, 4'b0000, 64'h0,                             1'b1, 4'b0000, 1'b0, 16'hE000, 2'd0, 1'b1, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      check("rst_ov",   64'(out_valid), 64'h0);
      check("rst_od",   64'(out_data),  64'h0);
      check("rst_ol",   64'(out_last),  64'h0);
      check("rst_id",   64'(out_id),    64'h0);
      check("rst_busy", 64'(busy),      64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].vld, tbl[i].last, tbl[i].data, tbl[i].ordy);
         #1;
         check($sformatf("v%0d_rdy",  i), 64'(req_ready), 64'(tbl[i].e_rdy));
         check($sformatf("v%0d_ov",   i), 64'(out_valid), 64'(tbl[i].e_ov));
         check($sformatf("v%0d_od",   i), 64'(out_data),  64'(tbl[i].e_od));
         check($sformatf("v%0d_id",   i), 64'(out_id),    64'(tbl[i].e_id));
         check($sformatf("v%0d_ol",   i), 64'(out_last),  64'(tbl[i].e_ol));
         check($sformatf("v%0d_busy", i), 64'(busy),      64'(tbl[i].e_busy));
      end

      // Reset mid-packet: ptr is 1 here, requester 2 takes and locks the stage.
      @(negedge clk);
      drive(4'b0100, 4'b0000, mk(16'h0, 16'hC000, 16'h0, 16'h0), 1'b1);
      #1;
      check("lk_rdy", 64'(req_ready), 64'h4);
      @(negedge clk);
      #1;
      check("lk_busy", 64'(busy),     64'h1);
      check("lk_od",   64'(out_data), 64'hC000);
      check("lk_id",   64'(out_id),   64'h2);
      rst_n = 1'b0;
      #1;
      check("mrst_ov",   64'(out_valid), 64'h0);
      check("mrst_od",   64'(out_data),  64'h0);
      check("mrst_id",   64'(out_id),    64'h0);
      check("mrst_busy", 64'(busy),      64'h0);
      @(negedge clk);
      drive(4'b0101, 4'b0101, mk(16'h0, 16'hC002, 16'h0, 16'hC001), 1'b1);
      rst_n = 1'b1;
      #1;
      check("post_rdy", 64'(req_ready), 64'h1);
      @(negedge clk);
      drive(4'b0000, 4'b0000, 64'h0, 1'b1);
      #1;
      check("post_ov", 64'(out_valid), 64'h1);
      check("post_od", 64'(out_data),  64'hC001);
      check("post_id", 64'(out_id),    64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cmm_pip_rr_arb.md
Name: cmm_pip_rr_arb

Overview:
- Round-robin arbiter that shares one pipelined elastic output stage among NREQ valid/ready requesters.
- Grants are packet-locked: once a requester wins, it owns the stage until its last beat is accepted.
- The output stage provides a full-throughput register slice with a direct combinational path from i_out_ready to the upstream readies.
- Sits in front of shared AXI-RAM append/write channels, where several masters push bursts into one pipeline.

Parameters:
NREQ, 4, number of requesters (>=1)
DWIDTH, 16, data width per requester
IDW, 2, width of source id output; must satisfy 2**IDW >= NREQ

Ports:
i_clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
i_req_valid  input  NREQ  per-requester beat valid
i_req_data  input  NREQ*DWIDTH  per-requester data, requester k at bits [k*DWIDTH +: DWIDTH]
i_req_last  input  NREQ  per-requester last beat of packet
o_req_ready  output  NREQ  per-requester ready, at most one bit high per cycle
i_out_ready  input  1  downstream ready
o_out_valid  output  1  output stage holds a beat
o_out_data  output  DWIDTH  registered beat data
o_out_last  output  1  registered last flag
o_out_id  output  IDW  registered index of the source requester
o_busy  output  1  high while in LOCKED state

Behaviour:
- Reset (async, rst_n=0):
  - o_out_valid=0, o_out_data=0, o_out_last=0, o_out_id=0.
  - State=IDLE, priority pointer ptr=0, owner=0, o_busy=0.
  - If reset asserts mid-packet, the packet is dropped and the lock is released. No state survives reset.
- Stage accept:
  - can_acc = !o_out_valid || i_out_ready (combinational).
  - A beat is accepted when o_req_ready[g] && i_req_valid[g].
- Grant (combinational, same cycle):
  - IDLE: g = first k with i_req_valid[k], scanning ptr, ptr+1, ... wrapping mod NREQ. No valid requester means no grant.
  - LOCKED: g = owner. Other requesters are never granted, even if the owner deasserts valid (bubble allowed).
  - o_req_ready[k] = can_acc && (k==g) && grant_exists. In LOCKED, grant_exists=1 regardless of owner valid.
- Output register on accept, at the clock edge:
  - o_out_data <= i_req_data[g]; o_out_last <= i_req_last[g]; o_out_id <= g; o_out_valid <= 1.
  - Latency: 1 cycle from accept to o_out_valid.
- Output register with no accept:
  - If i_out_ready=1, o_out_valid <= 0.
  - Otherwise all output registers hold. Data, last and id are stable while o_out_valid && !i_out_ready.
- Throughput: one beat per cycle sustained when i_out_ready is held 1.
- State machine (two states):
  - IDLE -> LOCKED: on an accepted beat with last=0; owner <= g.
  - IDLE -> IDLE: on an accepted beat with last=1; ptr <= (g+1) mod NREQ.
  - LOCKED -> IDLE: on an accepted owner beat with last=1; ptr <= (owner+1) mod NREQ.
  - LOCKED -> LOCKED: otherwise.
  - ptr is updated only on packet completion. Wrap: NREQ-1 -> 0.
- Simultaneous events: downstream drain and a new accept in the same cycle produce a back-to-back beat; o_out_valid stays 1.
- o_busy = (state==LOCKED).
- NREQ=1: the arbiter degenerates to a single elastic stage. ptr stays 0.

Test Plan:
- Reset, then i_req_valid=4'b0000 with i_out_ready=1 -> o_out_valid=0, o_req_ready=0, o_busy=0 for 10 cycles.
- Requesters 0 and 2 each hold single-beat packets (last=1) continuously, data 0xA000+k, i_out_ready=1 -> o_out_id sequence 0,2,0,2... one beat per cycle, each beat appearing 1 cycle after accept.
- Requester 1 sends a 3-beat packet (0x1111, 0x1112, 0x1113 with last) while requester 3 is valid throughout -> ids 1,1,1 then 3; o_busy high from the cycle after beat 0 until after beat 2; o_req_ready[3]=0 during the lock.
- Same as the previous case, but requester 1 drops valid for 2 cycles mid-packet -> 2-cycle bubble, no grant to requester 3, o_busy stays 1.
- Backpressure: i_out_ready=0 for 5 cycles with a beat held -> o_out_valid, o_out_data and o_out_id stable; o_req_ready all 0. When i_out_ready returns to 1, the next beat is accepted in the same cycle.
- Assert rst_n=0 mid-packet during a LOCKED state -> outputs clear immediately. After release, ptr=0 and requester 0 wins if valid.
